// File: rtl/cmd_fetch_seq_pkg.sv
// ---------------------------------------------------------------------------
// cmd_fetch_pkg
// Shared definitions for the command fetch sequencer:
//   - FSM state encoding (plain 3-bit constants, kept legacy-compatible)
//   - OPC_EMPTY: opcode value the command store returns when it has no frame
//   - byte-index constants for the two header bytes of a frame
//   - arg_lane(): maps a payload byte index onto its CMD_ARG byte lane
// ---------------------------------------------------------------------------
package cmd_fetch_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_STROBE_H  = 3'd1;
    localparam logic [2:0] ST_STROBE_L  = 3'd2;
    localparam logic [2:0] ST_SETTLE    = 3'd3;
    localparam logic [2:0] ST_CAPTURE   = 3'd4;
    localparam logic [2:0] ST_PRESENT   = 3'd5;
    localparam logic [2:0] ST_POLL_WAIT = 3'd6;
    localparam logic [2:0] ST_ERROR     = 3'd7;

    localparam logic [7:0] OPC_EMPTY = 8'h00;

    localparam logic [2:0] IDX_OP  = 3'd0;
    localparam logic [2:0] IDX_LEN = 3'd1;

    // Payload bytes start at index 2; byte k lands in CMD_ARG[8k+7:8k].
    function automatic logic [1:0] arg_lane(input logic [2:0] idx);
        logic [2:0] k;
        k = idx - 3'd2;
        return k[1:0];
    endfunction

endpackage

// File: rtl/cmd_fetch_seq_if.sv
// ---------------------------------------------------------------------------
// cmd_fetch_seq_if
// Frame hand-off from the fetch sequencer to the command decoder.
//   CMD_VALID  frame available (master -> slave)
//   CMD_READY  decoder accepts frame (slave -> master)
//   CMD_OP     frame opcode
//   CMD_LEN    payload byte count
//   CMD_ARG    payload, little-endian, unused bytes zero
// ---------------------------------------------------------------------------
interface cmd_fetch_seq_if;

    logic        CMD_VALID;
    logic        CMD_READY;
    logic [7:0]  CMD_OP;
    logic [2:0]  CMD_LEN;
    logic [31:0] CMD_ARG;

    modport master (
        output CMD_VALID,
        output CMD_OP,
        output CMD_LEN,
        output CMD_ARG,
        input  CMD_READY
    );

    modport slave (
        input  CMD_VALID,
        input  CMD_OP,
        input  CMD_LEN,
        input  CMD_ARG,
        output CMD_READY
    );

endinterface

// File: rtl/cmd_fetch_seq_strobe_timer.sv
// ---------------------------------------------------------------------------
// strobe_timer
// Loadable 8-bit down-counter used for every timed phase of the sequencer.
//   CLK       system clock
//   RST       asynchronous active-low reset
//   load      reload the counter with load_val this edge
//   load_val  phase length in cycles
//   done      high during the last cycle of the loaded phase
// A phase of N cycles is loaded with N; the counter reads N on the first
// cycle of the phase and 1 on the last, so done flags the final cycle.
// ---------------------------------------------------------------------------
module strobe_timer (
    input  logic       CLK,
    input  logic       RST,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] count;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign done = (count <= 8'd1);

endmodule

// File: rtl/cmd_fetch_seq.sv
// ---------------------------------------------------------------------------
// cmd_fetch_seq
// Drives the command memory's NEXT_CMD advance strobe, reads one byte per
// strobe and assembles frames (opcode, length, payload) for the decoder.
//   CLK       system clock
//   RST       asynchronous active-low reset
//   EN        enables fetching, only looked at in IDLE
//   NEXT_CMD  advance strobe to the command memory
//   MEM_DATA  current byte from the command memory
//   cmd       frame hand-off (valid/ready, opcode, length, payload)
//   BUSY      high in every state except IDLE
//   ERR       sticky frame error (length above MAX_LEN)
//   ERR_CLR   clears ERR and leaves the ERROR state
// Each byte takes PULSE_HI + PULSE_LO + SETTLE + 1 cycles:
// strobe high, strobe low, settle, then one capture cycle.
// ---------------------------------------------------------------------------
module cmd_fetch_seq
    import cmd_fetch_pkg::*;
#(
    parameter int PULSE_HI = 4,
    parameter int PULSE_LO = 4,
    parameter int SETTLE   = 3,
    parameter int POLL_GAP = 16,
    parameter int MAX_LEN  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    output logic              NEXT_CMD,
    input  logic [7:0]        MEM_DATA,
    cmd_fetch_seq_if.master   cmd,
    output logic              BUSY,
    output logic              ERR,
    input  logic              ERR_CLR
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [2:0]  byte_idx;
    logic [7:0]  op_q;
    logic [2:0]  len_q;
    logic [31:0] arg_q;
    logic        err_q;
    logic        strobe_q;
    logic        busy_q;
    logic        valid_q;

    logic        timer_load;
    logic [7:0]  timer_val;
    logic        timer_done;

    logic        len_bad;
    logic        last_payload;

    assign len_bad      = (MEM_DATA > MAX_LEN_B);
    // byte_idx - 1 equals the payload count once the final payload byte is up.
    assign last_payload = ((byte_idx - 3'd1) == len_q);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (EN) state_nx = ST_STROBE_H;
            end
            ST_STROBE_H: begin
                if (timer_done) state_nx = ST_STROBE_L;
            end
            ST_STROBE_L: begin
                if (timer_done) state_nx = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (timer_done) state_nx = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (byte_idx == IDX_OP) begin
                    state_nx = (MEM_DATA == OPC_EMPTY) ? ST_POLL_WAIT : ST_STROBE_H;
                end else if (byte_idx == IDX_LEN) begin
                    if (len_bad)
                        state_nx = ST_ERROR;
                    else if (MEM_DATA == 8'd0)
                        state_nx = ST_PRESENT;
                    else
                        state_nx = ST_STROBE_H;
                end else begin
                    state_nx = last_payload ? ST_PRESENT : ST_STROBE_H;
                end
            end
            ST_PRESENT: begin
                if (cmd.CMD_READY) state_nx = ST_IDLE;
            end
            ST_POLL_WAIT: begin
                if (timer_done) state_nx = ST_IDLE;
            end
            ST_ERROR: begin
                if (ERR_CLR) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // The phase counter reloads on every state change with the length of
    // the state being entered; untimed states load zero.
    always_comb begin
        timer_load = (state_nx != state);
        timer_val  = 8'd0;
        case (state_nx)
            ST_STROBE_H:  timer_val = 8'(PULSE_HI);
            ST_STROBE_L:  timer_val = 8'(PULSE_LO);
            ST_SETTLE:    timer_val = 8'(SETTLE);
            ST_POLL_WAIT: timer_val = 8'(POLL_GAP);
            default:      timer_val = 8'd0;
        endcase
    end

    strobe_timer u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // -----------------------------------------------------------------------
    // Control registers; status outputs are registered from state_nx so
    // NEXT_CMD is glitch-free and still drops the instant RST asserts.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= ST_IDLE;
            byte_idx <= IDX_OP;
            err_q    <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state    <= state_nx;
            strobe_q <= (state_nx == ST_STROBE_H);
            busy_q   <= (state_nx != ST_IDLE);
            valid_q  <= (state_nx == ST_PRESENT);

            if (state == ST_IDLE && EN) begin
                byte_idx <= IDX_OP;
            end else if (state == ST_CAPTURE) begin
                if (byte_idx == IDX_OP) begin
                    if (MEM_DATA != OPC_EMPTY) byte_idx <= IDX_LEN;
                end else if (byte_idx == IDX_LEN) begin
                    if (len_bad)
                        err_q <= 1'b1;
                    else
                        byte_idx <= byte_idx + 3'd1;
                end else begin
                    byte_idx <= byte_idx + 3'd1;
                end
            end

            if (state == ST_ERROR && ERR_CLR) err_q <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Frame registers; they keep their contents after acceptance until the
    // next frame starts, when the payload is cleared.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            op_q  <= 8'd0;
            len_q <= 3'd0;
            arg_q <= 32'd0;
        end else begin
            if (state == ST_IDLE && EN) begin
                arg_q <= 32'd0;
            end else if (state == ST_CAPTURE) begin
                if (byte_idx == IDX_OP) begin
                    if (MEM_DATA != OPC_EMPTY) op_q <= MEM_DATA;
                end else if (byte_idx == IDX_LEN) begin
                    if (!len_bad) len_q <= MEM_DATA[2:0];
                end else begin
                    arg_q[8*arg_lane(byte_idx) +: 8] <= MEM_DATA;
                end
            end
        end
    end

    assign NEXT_CMD      = strobe_q;
    assign BUSY          = busy_q;
    assign ERR           = err_q;
    assign cmd.CMD_VALID = valid_q;
    assign cmd.CMD_OP    = op_q;
    assign cmd.CMD_LEN   = len_q;
    assign cmd.CMD_ARG   = arg_q;

endmodule

// File: tb/tb_cmd_fetch_seq.sv
// ---------------------------------------------------------------------------
// tb_cmd_fetch_seq
// Bench for cmd_fetch_seq: a byte-queue command memory that advances on each
// NEXT_CMD rising edge, a cycle-level behavioural model that tracks elapsed
// fetch time arithmetically, a compare process checking every cycle, and
// directed plus randomized scenarios with hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_cmd_fetch_seq;

    localparam int PH = 4;
    localparam int PL = 4;
    localparam int ST = 3;
    localparam int PG = 16;
    localparam int ML = 4;
    localparam int F  = PH + PL + ST + 1;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_PRES  = 2;
    localparam int M_POLL  = 3;
    localparam int M_ERR   = 4;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic       NEXT_CMD;
    logic [7:0] MEM_DATA;
    logic       BUSY;
    logic       ERR;
    logic       ERR_CLR;

    cmd_fetch_seq_if bus ();

    cmd_fetch_seq #(
        .PULSE_HI (PH),
        .PULSE_LO (PL),
        .SETTLE   (ST),
        .POLL_GAP (PG),
        .MAX_LEN  (ML)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .NEXT_CMD (NEXT_CMD),
        .MEM_DATA (MEM_DATA),
        .cmd      (bus.master),
        .BUSY     (BUSY),
        .ERR      (ERR),
        .ERR_CLR  (ERR_CLR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_asrt = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_asrt++;
        n_fail++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    // ---------------- command memory model ----------------
    logic [7:0] memq[$];
    int         pulses = 0;

    initial begin
        logic prev;
        prev     = 1'b0;
        MEM_DATA = 8'h00;
        forever begin
            @(negedge CLK);
            if (NEXT_CMD === 1'b1 && !prev) begin
                pulses++;
                MEM_DATA = (memq.size() > 0) ? memq.pop_front() : 8'h00;
            end
            prev = (NEXT_CMD === 1'b1);
        end
    end

    // ---------------- behavioural model ----------------
    // m_t counts cycles since the frame (or poll wait) began; byte b of a
    // frame is strobed on cycles b*F .. b*F+PH-1 and captured on b*F+F-1.
    int          m_mode = M_IDLE;
    int          m_t    = 0;
    int          m_len  = 0;
    logic [7:0]  m_op   = 8'h00;
    logic [31:0] m_arg  = 32'h0;

    initial begin
        int         b;
        logic [7:0] d;
        forever begin
            @(posedge CLK or negedge RST);
            if (!RST) begin
                m_mode = M_IDLE;
                m_t    = 0;
                m_len  = 0;
                m_op   = 8'h00;
                m_arg  = 32'h0;
            end else begin
                case (m_mode)
                    M_IDLE: if (EN) begin
                        m_mode = M_FETCH;
                        m_t    = 0;
                        m_len  = 0;
                        m_arg  = 32'h0;
                    end
                    M_FETCH: begin
                        if (m_t % F == F - 1) begin
                            b = m_t / F;
                            d = MEM_DATA;
                            if (b == 0) begin
                                if (d == 8'h00) begin
                                    m_mode = M_POLL;
                                    m_t    = 0;
                                end else begin
                                    m_op = d;
                                    m_t++;
                                end
                            end else if (b == 1) begin
                                if (int'(d) > ML)  m_mode = M_ERR;
                                else if (d == 0)   m_mode = M_PRES;
                                else begin
                                    m_len = int'(d);
                                    m_t++;
                                end
                            end else begin
                                m_arg = m_arg | (32'(d) << (8 * (b - 2)));
                                if (b - 1 == m_len) m_mode = M_PRES;
                                else m_t++;
                            end
                        end else begin
                            m_t++;
                        end
                    end
                    M_PRES: if (bus.CMD_READY) m_mode = M_IDLE;
                    M_POLL: begin
                        if (m_t == PG - 1) m_mode = M_IDLE;
                        else m_t++;
                    end
                    M_ERR: if (ERR_CLR) m_mode = M_IDLE;
                    default: m_mode = M_IDLE;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST) begin
                chk("rst_next_cmd", 32'(NEXT_CMD), 32'd0);
                chk("rst_busy", 32'(BUSY), 32'd0);
                chk("rst_err", 32'(ERR), 32'd0);
                chk("rst_valid", 32'(bus.CMD_VALID), 32'd0);
                chk("rst_op", 32'(bus.CMD_OP), 32'd0);
                chk("rst_len", 32'(bus.CMD_LEN), 32'd0);
                chk("rst_arg", bus.CMD_ARG, 32'd0);
            end else begin
                chk("next_cmd", 32'(NEXT_CMD), 32'(m_mode == M_FETCH && (m_t % F) < PH));
                chk("busy", 32'(BUSY), 32'(m_mode != M_IDLE));
                chk("valid", 32'(bus.CMD_VALID), 32'(m_mode == M_PRES));
                chk("err", 32'(ERR), 32'(m_mode == M_ERR));
                if (m_mode == M_PRES) begin
                    chk("cmd_op", 32'(bus.CMD_OP), 32'(m_op));
                    chk("cmd_len", 32'(bus.CMD_LEN), 32'(m_len));
                    chk("cmd_arg", bus.CMD_ARG, m_arg);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (BUSY && n < 500) begin
            tick();
            n++;
        end
        if (BUSY) timeout("wait_idle");
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.CMD_VALID && n < 1000) begin
            tick();
            n++;
        end
        if (!bus.CMD_VALID) timeout("wait_valid");
    endtask

    task automatic load(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3, input int cnt);
        logic [7:0] bytes [4];
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        memq.delete();
        for (int i = 0; i < cnt; i++) memq.push_back(bytes[i]);
        pulses = 0;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int n;
        int vc;
        int r;
        int ln;

        RST = 1'b0;
        EN = 1'b0;
        ERR_CLR = 1'b0;
        bus.CMD_READY = 1'b1;
        repeat (3) tick();
        chk("reset_busy", 32'(BUSY), 32'd0);
        chk("reset_next_cmd", 32'(NEXT_CMD), 32'd0);
        RST = 1'b1;
        tick();

        // Basic frame with two payload bytes, always ready.
        load(8'h21, 8'h02, 8'hAA, 8'hBB, 4);
        EN = 1'b1;
        wait_valid(n);
        EN = 1'b0;
        chk("s1_latency", 32'(n), 32'd49);
        chk("s1_pulses", 32'(pulses), 32'd4);
        chk("s1_op", 32'(bus.CMD_OP), 32'h21);
        chk("s1_len", 32'(bus.CMD_LEN), 32'd2);
        chk("s1_arg", bus.CMD_ARG, 32'h0000BBAA);
        tick();
        chk("s1_valid_one_cycle", 32'(bus.CMD_VALID), 32'd0);

        // Empty store: one pulse, poll wait, then a fresh poll.
        wait_idle();
        load(8'h00, 8'h00, 8'h00, 8'h00, 0);
        EN = 1'b1;
        repeat (F + PG) tick();
        chk("s2_pulses_in_poll", 32'(pulses), 32'd1);
        chk("s2_busy_in_poll", 32'(BUSY), 32'd1);
        tick();
        tick();
        chk("s2_repoll", 32'(pulses), 32'd2);
        EN = 1'b0;
        wait_idle();

        // Length above MAX_LEN: error, no more strobes, clear and resume.
        load(8'h05, 8'h07, 8'h00, 8'h00, 2);
        EN = 1'b1;
        n = 0;
        while (!ERR && n < 500) begin
            tick();
            n++;
        end
        if (!ERR) timeout("s3_err");
        chk("s3_err_latency", 32'(n), 32'(2 * F + 1));
        chk("s3_pulses", 32'(pulses), 32'd2);
        repeat (20) tick();
        chk("s3_no_more_pulses", 32'(pulses), 32'd2);
        chk("s3_err_sticky", 32'(ERR), 32'd1);
        load(8'h33, 8'h01, 8'h77, 8'h00, 3);
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        chk("s3_err_cleared", 32'(ERR), 32'd0);
        wait_valid(n);
        EN = 1'b0;
        chk("s3_resume_op", 32'(bus.CMD_OP), 32'h33);
        chk("s3_resume_arg", bus.CMD_ARG, 32'h00000077);

        // Zero-length frame held by READY=0 for 10 cycles.
        wait_idle();
        bus.CMD_READY = 1'b0;
        load(8'h10, 8'h00, 8'h00, 8'h00, 2);
        EN = 1'b1;
        wait_valid(n);
        EN = 1'b0;
        vc = 1;
        repeat (9) begin
            tick();
            if (bus.CMD_VALID) vc++;
        end
        chk("s4_valid_cycles", 32'(vc), 32'd10);
        chk("s4_pulses", 32'(pulses), 32'd2);
        chk("s4_op", 32'(bus.CMD_OP), 32'h10);
        chk("s4_len", 32'(bus.CMD_LEN), 32'd0);
        chk("s4_arg", bus.CMD_ARG, 32'd0);
        bus.CMD_READY = 1'b1;
        tick();
        chk("s4_accepted", 32'(bus.CMD_VALID), 32'd0);

        // Reset during the third strobe, then a clean frame from opcode.
        wait_idle();
        load(8'h40, 8'h03, 8'h01, 8'h02, 4);
        EN = 1'b1;
        n = 0;
        while (pulses < 3 && n < 500) begin
            tick();
            n++;
        end
        if (pulses < 3) timeout("s5_third_strobe");
        chk("s5_strobe_high", 32'(NEXT_CMD), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        chk("s5_async_next_cmd", 32'(NEXT_CMD), 32'd0);
        chk("s5_async_busy", 32'(BUSY), 32'd0);
        tick();
        tick();
        load(8'h41, 8'h01, 8'h99, 8'h00, 3);
        RST = 1'b1;
        wait_valid(n);
        EN = 1'b0;
        chk("s5_latency", 32'(n), 32'(3 * F + 1));
        chk("s5_op", 32'(bus.CMD_OP), 32'h41);
        chk("s5_arg", bus.CMD_ARG, 32'h00000099);
        chk("s5_pulses", 32'(pulses), 32'd3);

        // EN dropped mid-frame: frame completes, nothing further.
        wait_idle();
        load(8'h30, 8'h01, 8'h5A, 8'h00, 3);
        EN = 1'b1;
        repeat (5) tick();
        EN = 1'b0;
        wait_valid(n);
        chk("s6_op", 32'(bus.CMD_OP), 32'h30);
        chk("s6_arg", bus.CMD_ARG, 32'h0000005A);
        repeat (30) tick();
        chk("s6_no_fetch", 32'(pulses), 32'd3);
        chk("s6_idle", 32'(BUSY), 32'd0);

        // Randomized frame stream and handshake inputs.
        memq.delete();
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                memq.push_back(8'h00);
            end else begin
                memq.push_back(8'($urandom_range(1, 255)));
                ln = (r == 1) ? int'($urandom_range(5, 255)) : int'($urandom_range(0, ML));
                memq.push_back(8'(ln));
                if (ln <= ML)
                    for (int k = 0; k < ln; k++) memq.push_back(8'($urandom_range(0, 255)));
            end
        end
        for (int c = 0; c < 4000; c++) begin
            tick();
            EN            = ($urandom_range(0, 7) != 0);
            bus.CMD_READY = $urandom_range(0, 1) == 1;
            ERR_CLR       = ($urandom_range(0, 7) == 0);
        end
        EN = 1'b0;
        ERR_CLR = 1'b1;
        bus.CMD_READY = 1'b1;
        wait_idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
